leaf_xbar_scheduler: RTL
========================

LEAF_XBAR_SCHEDULER -- requirements
Module: leaf_xbar_scheduler

Interface
REQ-001 SHALL have parameter GROUP_ID, default 4'b0011, local group number compared against dest_addr[5:2].
REQ-002 SHALL have parameter MAX_HOLD, default 16, count of consecutive no-transfer cycles that ends a grant; legal range 2..255.
REQ-003 SHALL have one clock, clk, with reset synchronous and active-high, named reset.
REQ-004 SHALL provide these ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- arb_enable  in  1  permits new grants.
- req  in  5  request per requester; bit0 = GPU, bits1..4 = spine1..spine4.
- req_dest_addr  in  30  6-bit destination per requester; requester i at [6i+5:6i].
- flit_valid  in  1  granted requester presents a flit.
- flit_last  in  1  flit is end of packet; qualified by flit_valid.
- out_ready  in  1  selected output accepts a flit.
- grant  out  5  one-hot grant, same bit order as req.
- current_grant  out  3  index 0..4 of the granted requester; 3'd7 when none.
- busy  out  1  high in XFER.
- direction  out  2  00 none, 01 up (GPU to spine), 10 down (spine to GPU), 11 GPU loopback.
- spine_sel  out  2  uplink spine index 0..3 for direction 01.
- misroute  out  1  one-cycle pulse.
- timeout_err  out  1  one-cycle pulse.

Function
REQ-005 SHALL define a flit transfer (fire) as flit_valid & out_ready in XFER.
REQ-006 SHALL treat requester i as eligible when req[i] is high and, for i = 1..4, req_dest_addr[6i+5:6i+2] == GROUP_ID.
- The GPU (i = 0) is always eligible when req[0] is high.
REQ-007 SHALL pulse misroute for one cycle in IDLE when arb_enable is high and any spine requester has req high with a non-local destination.
- That spine is never granted while its destination stays non-local.
REQ-008 SHALL implement an FSM with two states, IDLE and XFER.
REQ-009 In IDLE, with arb_enable high and at least one eligible requester, SHALL select the first eligible requester searching rr_ptr, rr_ptr+1, ... modulo 5, and enter XFER.
- grant, current_grant and direction are registered; they appear the cycle after the request is sampled, so latency is 1 cycle.
REQ-010 SHALL hold grant, current_grant, direction and spine_sel constant for the whole of XFER.
- Changes to req, req_dest_addr or arb_enable during XFER are ignored.
- Deasserting arb_enable never aborts a transfer.
REQ-011 SHALL set direction at grant time:
- 10 for a spine requester.
- 11 for the GPU when dest[5:2] == GROUP_ID.
- 01 for the GPU otherwise.
REQ-012 On fire with flit_last high, SHALL return to IDLE the next cycle, with grant = 0, current_grant = 7, direction = 00, busy = 0.
- rr_ptr is set to (granted index + 1) mod 5.
- The earliest next grant is 2 cycles after the last fire.
REQ-013 SHALL keep an idle counter in XFER: cleared on grant and on every fire, incremented on each cycle without a fire.
REQ-014 When the idle counter reaches MAX_HOLD-1 without a fire, SHALL return to IDLE, pulse timeout_err for one cycle, and advance rr_ptr as in REQ-012.
REQ-015 When a fire with flit_last and the timeout condition occur in the same cycle, SHALL give the fire precedence; no timeout_err is raised.
REQ-016 SHALL advance spine_sel by 1 modulo 4 (3 wraps to 0) when a direction-01 grant ends, whether by last fire or by timeout.
- spine_sel is otherwise unchanged.
REQ-017 SHALL keep grant one-hot or zero at all times, and current_grant consistent with grant.

Reset
REQ-018 While reset is high at a clock edge, SHALL set:
- state = IDLE, grant = 0, current_grant = 3'd7, busy = 0, direction = 00.
- spine_sel = 0, rr_ptr = 0, idle counter = 0, misroute = 0, timeout_err = 0.
REQ-019 Reset during XFER SHALL abandon the transfer with no timeout_err.
- The first grant is possible 1 cycle after reset deasserts.

Verification
REQ-020 SHALL pass these directed scenarios:
- Round-robin: req = 5'b11111, all local, 1-flit packets with out_ready = 1 -> grant order 0, 1, 2, 3, 4, 0.
- GPU uplink, dest 6'b000100 (group 1): grants give direction 01 with spine_sel 0, 1, 2, 3, 0 on successive packets.
- GPU loopback, dest 6'b001100: direction = 11 and spine_sel unchanged afterwards.
- Misroute: spine2 req with dest[5:2] = 4'b0101 -> one-cycle misroute pulse and no grant to spine2; a GPU req is still granted.
- Timeout, MAX_HOLD = 4: grant GPU, hold flit_valid = 0 -> timeout_err pulses and grant drops after 4 idle cycles, then rr_ptr = 1.
- Reset mid-XFER after 2 flits -> next cycle grant = 0, current_grant = 7, spine_sel = 0; with arb_enable = 0 no new grant even when req = 5'b11111.

Source files
------------

// File: rtl/leaf_xbar_scheduler.sv
// Leaf crossbar scheduler: round-robin grant of one GPU port and four spine
// uplinks onto a shared crossbar path. A grant is held for a whole packet and
// ends on the last flit or after MAX_HOLD consecutive cycles with no transfer.
// Uplink (GPU to spine) grants rotate across the four spines.
module leaf_xbar_scheduler #(
    parameter logic [3:0]  GROUP_ID = 4'b0011,  // local group, compared with dest[5:2]
    parameter int unsigned MAX_HOLD = 16        // stall cycles that end a grant, 2..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arb_enable,
    input  logic [4:0]  req,
    input  logic [29:0] req_dest_addr,
    input  logic        flit_valid,
    input  logic        flit_last,
    input  logic        out_ready,
    output logic [4:0]  grant,
    output logic [2:0]  current_grant,
    output logic        busy,
    output logic [1:0]  direction,
    output logic [1:0]  spine_sel,
    output logic        misroute,
    output logic        timeout_err
);

    localparam int          NUM_REQ   = 5;
    localparam logic [2:0]  NO_GRANT  = 3'd7;
    localparam logic [7:0]  HOLD_LAST = 8'(MAX_HOLD - 1);

    localparam logic [1:0]  DIR_NONE  = 2'b00;
    localparam logic [1:0]  DIR_UP    = 2'b01;  // GPU to a spine
    localparam logic [1:0]  DIR_DOWN  = 2'b10;  // spine to GPU
    localparam logic [1:0]  DIR_LOOP  = 2'b11;  // GPU to a local GPU

    typedef enum logic {
        IDLE,
        XFER
    } state_e;

    // Requester index after idx, wrapping 4 back to 0.
    function automatic logic [2:0] next_index(input logic [2:0] idx);
        return (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  grant_q, grant_d;
    logic [2:0]  current_grant_q, current_grant_d;
    logic [1:0]  direction_q, direction_d;
    logic [1:0]  spine_sel_q, spine_sel_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;
    logic        misroute_q, misroute_d;
    logic        timeout_err_q, timeout_err_d;

    logic [4:0]  eligible;
    logic [4:0]  misrouted;
    logic        gpu_local;
    logic        pick_found;
    logic [2:0]  pick_idx;
    logic [2:0]  cand;
    logic        fire;
    logic        end_grant;

    // The two low bits of each destination select a port inside the target
    // group and play no part in scheduling.
    logic        unused_dest_bits;
    assign unused_dest_bits = ^{req_dest_addr[25:24], req_dest_addr[19:18],
                                req_dest_addr[13:12], req_dest_addr[7:6],
                                req_dest_addr[1:0]};

    assign gpu_local = (req_dest_addr[5:2] == GROUP_ID);
    assign fire      = (state_q == XFER) && flit_valid && out_ready;

    // Split requests into grantable ones and spine requests aimed off-group.
    always_comb begin
        eligible    = '0;
        misrouted   = '0;
        eligible[0] = req[0];
        for (int i = 1; i < NUM_REQ; i++) begin
            if (req_dest_addr[6*i+2 +: 4] == GROUP_ID) begin
                eligible[i] = req[i];
            end else begin
                misrouted[i] = req[i];
            end
        end
    end

    // Round-robin search starting at rr_ptr; first eligible requester wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // through this block leaves a value unassigned and no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        cand       = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
            cand = next_index(cand);
        end
    end

    // Next-state logic: grant from IDLE, hold and watch for packet end in XFER.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        current_grant_d = current_grant_q;
        direction_d     = direction_q;
        spine_sel_d     = spine_sel_q;
        rr_ptr_d        = rr_ptr_q;
        idle_cnt_d      = idle_cnt_q;
        misroute_d      = 1'b0;
        timeout_err_d   = 1'b0;
        end_grant       = 1'b0;

        case (state_q)
            IDLE: begin
                misroute_d = arb_enable && (|misrouted);
                if (arb_enable && pick_found) begin
                    state_d         = XFER;
                    grant_d         = 5'b00001 << pick_idx;
                    current_grant_d = pick_idx;
                    idle_cnt_d      = 8'd0;
                    if (pick_idx != 3'd0) begin
                        direction_d = DIR_DOWN;
                    end else if (gpu_local) begin
                        direction_d = DIR_LOOP;
                    end else begin
                        direction_d = DIR_UP;
                    end
                end
            end

            XFER: begin
                // A last-flit fire wins over a timeout landing in the same cycle.
                if (fire) begin
                    idle_cnt_d = 8'd0;
                    end_grant  = flit_last;
                end else if (idle_cnt_q == HOLD_LAST) begin
                    end_grant     = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end

                if (end_grant) begin
                    state_d         = IDLE;
                    grant_d         = '0;
                    current_grant_d = NO_GRANT;
                    direction_d     = DIR_NONE;
                    idle_cnt_d      = 8'd0;
                    rr_ptr_d        = next_index(current_grant_q);
                    if (direction_q == DIR_UP) begin
                        spine_sel_d = spine_sel_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample the pre-edge
        // values, so the order of these statements does not matter.
        if (reset) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            current_grant_q <= NO_GRANT;
            direction_q     <= DIR_NONE;
            spine_sel_q     <= 2'd0;
            rr_ptr_q        <= 3'd0;
            idle_cnt_q      <= 8'd0;
            misroute_q      <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            current_grant_q <= current_grant_d;
            direction_q     <= direction_d;
            spine_sel_q     <= spine_sel_d;
            rr_ptr_q        <= rr_ptr_d;
            idle_cnt_q      <= idle_cnt_d;
            misroute_q      <= misroute_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign grant         = grant_q;
    assign current_grant = current_grant_q;
    assign busy          = (state_q == XFER);
    assign direction     = direction_q;
    assign spine_sel     = spine_sel_q;
    assign misroute      = misroute_q;
    assign timeout_err   = timeout_err_q;

endmodule
